// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared FSM encoding, queue entry layout and PC step for the
//                instruction-fetch prefetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int unsigned PC_STEP = 4;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REQ    = 2'd1;
    localparam logic [1:0] c_SQUASH = 2'd2;

    // Reference entry layout; the top re-declares it with its own widths.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_fifo
//  Description : DEPTH-entry synchronous FIFO with clear, count, full/empty
//                and a registered head that holds its last value when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_fifo
    import if_pkg::*;
#(
    parameter type         entry_t = if_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output entry_t                 head_next,
    output logic                   head_load,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    entry_t             r_mem [DEPTH];
    entry_t             r_head;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_CNT_W-1:0] w_count_rem;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty       = (r_count == '0);
    assign full        = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop    = pop & ~empty;
    assign w_do_push   = push & (~full | w_do_pop | clear);
    assign w_count_rem = r_count - c_CNT_W'(w_do_pop);

    // The head register is reloaded from the pushed word whenever the queue
    // would otherwise have nothing stored behind the current head.
    always_comb begin
        w_wr_idx     = r_wr_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        head_next    = r_head;
        head_load    = 1'b0;
        if (clear) begin
            w_wr_idx     = '0;
            w_wr_ptr_nxt = push ? c_PTR_W'(1) : '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = push ? c_CNT_W'(1) : '0;
            head_next    = push_data;
            head_load    = push;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(w_do_push);
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_do_pop);
            w_count_nxt  = w_count_rem + c_CNT_W'(w_do_push);
            head_next    = (w_count_rem == '0) ? push_data : r_mem[w_rd_ptr_nxt];
            head_load    = (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (head_load) begin
                r_head <= head_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch
//  Description : Instruction-fetch stage: sequential req/ack reads into a
//                prefetch queue, redirect flush/squash, valid/ready to decode.
//                Optional macro IF_PREFETCH_ALIGN_CHECK_EN: misaligned
//                redirect targets yield a single fault entry instead of reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_reset,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              read_req,
    input  logic              read_ack,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              fault
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic              fault;
    } entry_t;

    localparam int unsigned       c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(PC_STEP);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  w_fetch_pc_nxt;
    logic [ADDR_W-1:0]  r_read_addr;
    logic [ADDR_W-1:0]  r_pc_next;
    logic [ADDR_W-1:0]  w_target_raw;
    logic [ADDR_W-1:0]  w_target;
    logic               r_parked;
    logic               w_parked_nxt;
    logic               w_redirect;
    logic               w_misaligned;
    logic               w_push;
    logic               w_fifo_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_head_load;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_count_after;
    entry_t             w_push_entry;
    entry_t             w_head;
    entry_t             w_head_next;

    assign w_redirect = pc_reset | is_jump | is_branch;

    always_comb begin
        w_target_raw = jump_addr;
        if (pc_reset) begin
            w_target_raw = RESET_PC;
        end else if (is_branch) begin
            w_target_raw = branch_addr;
        end
    end

`ifdef IF_PREFETCH_ALIGN_CHECK_EN
    localparam logic c_ALIGN_EN = 1'b1;
    assign w_target     = w_target_raw;
    assign w_misaligned = w_redirect & (w_target_raw[1:0] != 2'b00);
`else
    localparam logic              c_ALIGN_EN   = 1'b0;
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(3);
    assign w_target     = w_target_raw & c_ALIGN_MASK;
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_push_entry.pc    = r_read_addr;
        w_push_entry.instr = read_data;
        w_push_entry.fault = 1'b0;
        if (w_misaligned) begin
            w_push_entry.pc    = w_target;
            w_push_entry.instr = '0;
            w_push_entry.fault = 1'b1;
        end
    end

    assign w_push        = (r_state == c_REQ) & read_ack & ~w_redirect;
    assign w_fifo_push   = w_push | w_misaligned;
    assign w_pop         = out_valid & out_ready;
    assign w_count_after = w_count + c_CNT_W'(1) - c_CNT_W'(w_pop);

    // A request is only raised when the queue is guaranteed a slot for it;
    // an outstanding read is never abandoned, only its data is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_parked_nxt   = r_parked;
        if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
            w_parked_nxt   = w_misaligned;
            w_state_nxt    = ((r_state != c_IDLE) && !read_ack) ? c_SQUASH : c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!r_parked && !w_full) begin
                        w_state_nxt = c_REQ;
                    end
                end
                c_REQ: begin
                    if (read_ack) begin
                        w_fetch_pc_nxt = r_fetch_pc + c_STEP;
                        w_state_nxt    = (w_count_after < c_CNT_W'(DEPTH)) ? c_REQ : c_IDLE;
                    end
                end
                c_SQUASH: begin
                    if (read_ack) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_read_addr <= RESET_PC;
            r_parked    <= 1'b0;
            r_pc_next   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_parked   <= w_parked_nxt;
            if (w_state_nxt != c_SQUASH) begin
                r_read_addr <= w_fetch_pc_nxt;
            end
            if (w_head_load) begin
                r_pc_next <= w_head_next.pc + c_STEP;
            end
        end
    end

    if_prefetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_redirect),
        .push      (w_fifo_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .head_next (w_head_next),
        .head_load (w_head_load),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign read_req    = (r_state != c_IDLE);
    assign read_addr   = r_read_addr;
    assign out_valid   = ~w_empty;
    assign instruction = w_head.instr;
    assign pc          = w_head.pc;
    assign pc_next     = r_pc_next;
    assign fault       = c_ALIGN_EN & w_head.fault;

endmodule
`default_nettype wire

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue. It issues sequential word reads to the memory arbiter over a req/ack handshake and buffers up to DEPTH fetched instructions with their PCs. It presents them to decode through a valid/ready interface. Jump/branch redirects and PC reset flush the queue and squash any in-flight read; it sits between the arbiter and the decode stage.

## Interface
- ADDR_W, 32, fetch address / PC width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset or pc_reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_reset  in  1  restart fetch at RESET_PC (redirect semantics)
- is_jump  in  1  redirect to jump_addr
- is_branch  in  1  redirect to branch_addr; wins over is_jump
- jump_addr, branch_addr  in  ADDR_W  redirect targets
- read_req  out  1  arbiter request
- read_ack  in  1  arbiter completion; read_data valid this cycle
- read_addr  out  ADDR_W  request address
- read_data  in  DATA_W  returned word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- instruction  out  DATA_W  head instruction
- pc  out  ADDR_W  head address
- pc_next  out  ADDR_W  pc + 4, modulo 2^ADDR_W
- fault  out  1  head is a misaligned-target fault (only with IF_PREFETCH_ALIGN_CHECK_EN; else tied 0)

## Operation
- Redirect = pc_reset | is_jump | is_branch. Priority: pc_reset > is_branch > is_jump.
- fetch_pc register: next address to request; wraps modulo 2^ADDR_W on +4.
- FSM, 3 states:
  - IDLE: when queue has a free slot (count + pending < DEPTH), assert read_req with read_addr = fetch_pc → REQ.
  - REQ: read_req and read_addr held stable until read_ack. On ack: push {fetch_pc, read_data}, fetch_pc += 4. If a slot remains, stay in REQ with the new address (back-to-back), else → IDLE.
  - SQUASH: entered on a redirect while in REQ without ack that cycle. Keep read_req high until ack, discard data, then → IDLE with fetch_pc = target.
- Redirect in IDLE, or in REQ coinciding with ack: ack data discarded, fetch_pc = target, → IDLE.
- Redirect always clears the queue at the same edge. It wins over a simultaneous pop and push.
- Pop on out_valid & out_ready. Push and pop in the same cycle are allowed when full.
- Without the macro, target bits [1:0] are forced to 00.

## Timing
- Reset values: read_req 0, read_addr RESET_PC, fetch_pc RESET_PC, out_valid 0, instruction 0, pc 0, pc_next 0, fault 0, FSM IDLE, count 0.
- First read_req is high on the first edge after reset release.
- Latency read_ack → out_valid: 1 cycle (queue head registered).
- Redirect at edge N: out_valid 0 from N+1. The first request to the target is at N+1 from IDLE, or the cycle after the squashed ack.
- Sustained throughput: one instruction per cycle while the arbiter acks every cycle and decode is ready.
- Full queue: read_req stays low, and no request is ever issued without a guaranteed slot.
- Empty queue: out_valid 0; instruction/pc hold last values.

## Configuration
- IF_PREFETCH_ALIGN_CHECK_EN defined:
  - A redirect target with bits [1:0] ≠ 0 issues no read.
  - A single entry {pc = target, instruction 0, fault 1} is pushed.
  - The FSM parks in IDLE until the next redirect.
- Not defined: low bits are masked to 0, there is no fault state, and the fault port is tied 0.

## Structure
- Shared package if_pkg: FSM state encoding, queue entry struct {pc, instr, fault}, PC_STEP = 4 constant.
- One sub-module: if_prefetch_fifo, a DEPTH×entry synchronous FIFO with clear, count, full/empty, and a registered head.

## Test plan
- Reset release, arbiter acks 1 cycle after each req with data = addr ^ 32'hA5A5_0000, out_ready=1:
  - required: requests to 0x0, 0x4, 0x8, …
  - required: out_valid with pc=0x0, pc_next=0x4 one cycle after first ack.
- out_ready=0 with DEPTH=4: exactly 4 acks occur, then read_req stays 0. Raising out_ready drains in order 0x0…0xC and fetch resumes at 0x10.
- is_branch=1, branch_addr=0x100 while REQ for 0x8 is unacked:
  - required: read_req stays high until ack and the data is discarded.
  - required: next request is 0x100, and the queue is empty the cycle after the redirect.
- is_jump and is_branch together (0x200 / 0x300): fetch goes to 0x300. Redirect coincident with ack: the acked word is never output.
- fetch_pc at 0xFFFF_FFFC: the next request is 0x0, and pc_next for that entry is 0x0.
- With the macro, branch_addr=0x102: no read_req, one entry with fault=1 and pc=0x102, then idle. Without the macro, a request to 0x100.
